// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - sync-word framed serial receiver; optional even parity via SERRX_PARITY_EN
module serial_frame_rx #(
  parameter int         DATA_W = 8,
  parameter logic [3:0] SYNC   = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              perr,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [2:0]        hist;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] pay_shift;
  logic              sync_hit;
  logic              last_bit;
  logic              frame_done;
  logic [DATA_W-1:0] frame_word;
  logic              frame_bad;

  assign pay_shift = {payload[DATA_W-2:0], din};
  assign sync_hit  = ({hist, din} == SYNC);
  assign last_bit  = (cnt == LAST_BIT);

`ifdef SERRX_PARITY_EN
  // The parity bit arrives one edge after the payload; the frame closes there.
  assign frame_done = (state == PARITY);
  assign frame_word = payload;
  assign frame_bad  = (^payload) ^ din;
`else
  // The frame closes on the last payload bit; the word includes that bit.
  assign frame_done = (state == DATA) && last_bit;
  assign frame_word = pay_shift;
  assign frame_bad  = 1'b0;
`endif

  // State register; reset wins over any sync match or frame completion.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state decode: hunt for sync, count payload bits, optional parity bit.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:   if (sync_hit) state_nxt = DATA;
      DATA: begin
        if (last_bit) begin
`ifdef SERRX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = HUNT;
`endif
        end
      end
      PARITY: state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Datapath: sync history, bit counter, payload shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      cnt       <= '0;
      payload   <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      perr      <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      dout_vld <= 1'b0;
      perr     <= 1'b0;
      busy     <= (state_nxt != HUNT);

      if (state == HUNT) begin
        // Bits inside a frame never feed sync detection, so history restarts empty.
        hist <= sync_hit ? 3'b000 : {hist[1:0], din};
        cnt  <= '0;
      end else begin
        hist <= '0;
      end

      if (state == DATA) begin
        payload <= pay_shift;
        cnt     <= cnt + 5'd1;
      end

      if (frame_done) begin
        dout     <= frame_word;
        dout_vld <= 1'b1;
        perr     <= frame_bad;
        if (!frame_bad) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal 2..16).
REQ-002 SHALL have parameter SYNC, default 4'b1011, meaning the 4-bit sync word, received MSB first.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  1  serial bit stream from the upstream 4-bit shift register (its dout), one bit per clk.
REQ-006 SHALL have port dout  output  DATA_W  last received payload, MSB first on the wire.
REQ-007 SHALL have port dout_vld  output  1  one-cycle pulse when dout is updated.
REQ-008 SHALL have port perr  output  1  parity error flag, qualified by dout_vld.
REQ-009 SHALL have port busy  output  1  high while in DATA or PARITY state.
REQ-010 SHALL have port frame_cnt  output  8  count of good frames received.

Function
REQ-011 SHALL sample din on every rising clk edge; no enable or handshake, and no backpressure.
REQ-012 SHALL implement FSM states HUNT, DATA, PARITY; PARITY is reachable only when SERRX_PARITY_EN is defined.
REQ-013 HUNT: 3-bit history register shifts din in each edge; at edge E where {hist,din}==SYNC, next state SHALL be DATA, bit counter cleared to 0.
REQ-014 DATA: edges E+1..E+DATA_W SHALL shift din into the payload register MSB first, counter incrementing 0..DATA_W-1.
REQ-015 Bits received in DATA or PARITY SHALL NOT be used for sync detection; history SHALL be cleared to 0 when leaving HUNT.
REQ-016 Without parity, after the edge at E+DATA_W, dout SHALL hold the payload and dout_vld SHALL be 1 for exactly one cycle; state returns to HUNT.
REQ-017 With parity, edge E+DATA_W+1 SHALL capture the parity bit; dout and dout_vld update after that edge, and perr = 1 if payload XOR parity bit != 0 (even parity).
REQ-018 The bit sampled on the edge following the last frame bit SHALL be the first history bit of the next hunt; back-to-back frames with no gap SHALL be received.
REQ-019 dout SHALL hold its value between pulses; perr SHALL be 0 whenever dout_vld is 0.
REQ-020 frame_cnt SHALL increment by 1 on each dout_vld with perr==0, and wrap 255 -> 0.
REQ-021 busy SHALL be registered and high exactly in the cycles the FSM is in DATA or PARITY.

Reset
REQ-022 rst high at a clk edge SHALL force state HUNT, history 0, counter 0, dout 0, dout_vld 0, perr 0, busy 0, frame_cnt 0.
REQ-023 rst asserted mid-frame SHALL discard the partial frame with no dout_vld; hunting restarts on the first edge with rst low.
REQ-024 rst SHALL take priority over all other events on the same edge, including a sync match or frame completion.

Configuration
REQ-025 Macro SERRX_PARITY_EN defined: one even-parity bit follows the payload, PARITY state present, perr is driven per REQ-017.
REQ-026 SERRX_PARITY_EN undefined: frame is SYNC + DATA_W bits only, perr is tied 0, and every frame counts as good.

Verification
REQ-027 rst=1 for 2 edges with din toggling -> all outputs 0, busy 0, no dout_vld.
REQ-028 No parity, defaults: din = 1,0,1,1 then 1,0,1,0,0,1,0,1 -> dout=8'hA5, dout_vld pulse one cycle after the 12th bit edge, frame_cnt=1.
REQ-029 Two frames back-to-back (sync+0xA5, sync+0x3C) with no gap -> two pulses 12 cycles apart, dout 0xA5 then 0x3C, frame_cnt=2.
REQ-030 Payload 0x0B (contains SYNC) followed by a 0 bit -> only the 0x0B frame is reported, with no false frame from payload bits.
REQ-031 rst pulsed on the 5th payload bit, then a full sync+0xFF frame -> no pulse for the aborted frame, dout=0xFF, frame_cnt=1.
REQ-032 SERRX_PARITY_EN: sync+0xA5+parity 0 -> perr=0, frame_cnt increments; sync+0xA5+parity 1 -> dout_vld with perr=1, frame_cnt unchanged.
